// File: rtl/word_unit_sequencer.sv
// rtl/word_unit_sequencer.sv - fetch/decode/issue sequencer driving the word unit control strobes
// Optional illegal-instruction trap: define SEQ_TRAP_ILLEGAL_EN to halt on classes 0x8-0xF
// and expose the sticky SEQ_Illegal flag; otherwise those classes execute as NOP.
module word_unit_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            CLK,
  input  logic            CPU_Reset,
  input  logic            SEQ_Run,
  output logic [PC_W-1:0] SEQ_PC,
  input  logic [15:0]     SEQ_Instr,
  output logic [7:0]      SEQ_RAMAddr,
  input  logic            SEQ_ComparatorResoult,
  output logic            SEQ_A_WE,
  output logic            SEQ_B_WE,
  output logic [1:0]      SEQ_A_OPCode,
  output logic [1:0]      SEQ_B_OPCode,
  output logic [3:0]      SEQ_ALU_OPCode,
  output logic            SEQ_OV_EN,
  output logic            SEQ_COMPARATORREG_EN,
  output logic [7:0]      SEQ_ArgToSet,
`ifdef SEQ_TRAP_ILLEGAL_EN
  output logic            SEQ_Illegal,
`endif
  output logic            SEQ_Halted
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [PC_W-1:0] pc, pc_next;
  logic [15:0]     ir;
  logic [3:0]      ir_class;
  logic [3:0]      ir_sub;
  logic [7:0]      ir_arg;
  logic [PC_W-1:0] jump_target;
  logic            exec;

`ifdef SEQ_TRAP_ILLEGAL_EN
  logic illegal, illegal_next;
  assign SEQ_Illegal = illegal;
`endif

  assign ir_class    = ir[15:12];
  assign ir_sub      = ir[11:8];
  assign ir_arg      = ir[7:0];
  assign jump_target = PC_W'(ir_arg);

  // Strobes only fire in EXEC, and are killed immediately by a reset sampled in that cycle
  assign exec = (state == ST_EXEC) && !CPU_Reset;

  assign SEQ_PC       = pc;
  assign SEQ_Halted   = (state == ST_HALT);
  assign SEQ_ArgToSet = ir_arg;
  // Address the data RAM with the incoming word during DECODE so its data lands in EXEC
  assign SEQ_RAMAddr  = (state == ST_DECODE) ? SEQ_Instr[7:0] : ir_arg;

  // State, program counter, instruction register and trap flag
  always_ff @(posedge CLK) begin
    if (CPU_Reset) begin
      state <= ST_FETCH;
      pc    <= '0;
      ir    <= '0;
`ifdef SEQ_TRAP_ILLEGAL_EN
      illegal <= 1'b0;
`endif
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == ST_DECODE) begin
        ir <= SEQ_Instr;
      end
`ifdef SEQ_TRAP_ILLEGAL_EN
      illegal <= illegal_next;
`endif
    end
  end

  // Next-state, next-PC and strobe decode
  always_comb begin
    state_next           = state;
    pc_next              = pc;
    SEQ_A_WE             = 1'b0;
    SEQ_B_WE             = 1'b0;
    SEQ_OV_EN            = 1'b0;
    SEQ_COMPARATORREG_EN = 1'b0;
    SEQ_A_OPCode         = ir_sub[1:0];
    SEQ_B_OPCode         = ir_sub[1:0];
    SEQ_ALU_OPCode       = ir_sub;
`ifdef SEQ_TRAP_ILLEGAL_EN
    illegal_next         = illegal;
`endif
    if (ir_class == 4'h3) begin
      SEQ_A_OPCode = 2'd3;
    end

    case (state)
      ST_FETCH: begin
        if (SEQ_Run) begin
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        state_next = ST_FETCH;
        pc_next    = pc + PC_W'(1);
        case (ir_class)
          4'h0: ;
          4'h1: SEQ_A_WE = exec;
          4'h2: SEQ_B_WE = exec;
          4'h3: begin
            SEQ_A_WE  = exec;
            SEQ_OV_EN = exec;
          end
          4'h4: SEQ_COMPARATORREG_EN = exec;
          4'h5: pc_next = jump_target;
          4'h6: begin
            if (SEQ_ComparatorResoult) begin
              pc_next = jump_target;
            end
          end
          4'h7: begin
            state_next = ST_HALT;
            pc_next    = pc;
          end
          default: begin
`ifdef SEQ_TRAP_ILLEGAL_EN
            state_next   = ST_HALT;
            pc_next      = pc;
            illegal_next = 1'b1;
`endif
          end
        endcase
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_word_unit_sequencer.sv
// tb/tb_word_unit_sequencer.sv - self-checking bench for word_unit_sequencer with an instruction-level model
module tb_word_unit_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [7:0]  pc_out;
    logic [15:0] instr = 16'h0;
    logic [7:0]  ram_addr;
    logic        cmp = 1'b0;
    logic        a_we, b_we, ov_en, cmpreg_en, halted;
    logic [1:0]  a_op, b_op;
    logic [3:0]  alu_op;
    logic [7:0]  arg_out;
`ifdef SEQ_TRAP_ILLEGAL_EN
    logic        illegal_out;
`endif

    logic [15:0] mem [256];
    logic [7:0]  m_pc;
    bit          m_halted;
    bit          m_ill;
    int          n_checks = 0;
    int          n_fail = 0;

    wire [3:0] strobes = {a_we, b_we, ov_en, cmpreg_en};

    word_unit_sequencer #(.PC_W(8)) dut (
        .CLK                   (clk),
        .CPU_Reset             (rst),
        .SEQ_Run               (run),
        .SEQ_PC                (pc_out),
        .SEQ_Instr             (instr),
        .SEQ_RAMAddr           (ram_addr),
        .SEQ_ComparatorResoult (cmp),
        .SEQ_A_WE              (a_we),
        .SEQ_B_WE              (b_we),
        .SEQ_A_OPCode          (a_op),
        .SEQ_B_OPCode          (b_op),
        .SEQ_ALU_OPCode        (alu_op),
        .SEQ_OV_EN             (ov_en),
        .SEQ_COMPARATORREG_EN  (cmpreg_en),
        .SEQ_ArgToSet          (arg_out),
`ifdef SEQ_TRAP_ILLEGAL_EN
        .SEQ_Illegal           (illegal_out),
`endif
        .SEQ_Halted            (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) instr <= mem[pc_out];

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (pc_out !== 8'h00 || halted !== 1'b0 || strobes !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h halted=%b strobes=%b expected pc=00 halted=0 strobes=0000",
                     pc_out, halted, strobes);
        end
        rst = 1'b0;
        m_pc = 8'h00;
        m_halted = 0;
        m_ill = 0;
    endtask

    task automatic do_instr(input int cmp_sel, input bit stall);
        logic [15:0] w;
        logic [3:0]  cls, sub, e_str, e_alu;
        logic [7:0]  arg, e_pc;
        logic [1:0]  e_aop, e_bop;
        bit          c, e_halt, e_ill;
        int          n;
        if (m_halted) return;
        n = stall ? $urandom_range(0, 2) : 0;
        for (int i = 0; i <= n; i++) begin
            n_checks++;
            if (pc_out !== m_pc || strobes !== 4'b0000) begin
                n_fail++;
                $display("FAIL fetch_pc: pc=%h strobes=%b expected pc=%h strobes=0000", pc_out, strobes, m_pc);
            end
            run = (i == n);
            @(negedge clk);
        end
        w = mem[m_pc];
        cls = w[15:12];
        sub = w[11:8];
        arg = w[7:0];
        n_checks++;
        if (ram_addr !== arg || strobes !== 4'b0000) begin
            n_fail++;
            $display("FAIL decode_ramaddr: addr=%h strobes=%b expected addr=%h strobes=0000", ram_addr, strobes, arg);
        end
        c = (cmp_sel == 2) ? 1'($urandom_range(0, 1)) : (cmp_sel == 1);
        cmp = c;
        run = 1'($urandom_range(0, 1));
        @(negedge clk);

        e_str = 4'b0000;
        e_alu = sub;
        e_aop = sub[1:0];
        e_bop = sub[1:0];
        e_pc = m_pc + 8'd1;
        e_halt = 0;
        e_ill = m_ill;
        case (cls)
            4'h0: ;
            4'h1: e_str = 4'b1000;
            4'h2: e_str = 4'b0100;
            4'h3: begin e_str = 4'b1010; e_aop = 2'd3; end
            4'h4: e_str = 4'b0001;
            4'h5: e_pc = arg;
            4'h6: e_pc = c ? arg : m_pc + 8'd1;
            4'h7: begin e_halt = 1; e_pc = m_pc; end
            default: begin
`ifdef SEQ_TRAP_ILLEGAL_EN
                e_halt = 1;
                e_pc = m_pc;
                e_ill = 1;
`endif
            end
        endcase
        n_checks++;
        if (strobes !== e_str) begin
            n_fail++;
            $display("FAIL exec_strobes: instr=%h strobes=%b expected %b", w, strobes, e_str);
        end
        n_checks++;
        if (arg_out !== arg) begin
            n_fail++;
            $display("FAIL exec_arg: instr=%h arg=%h expected %h", w, arg_out, arg);
        end
        if (e_str[3]) begin
            n_checks++;
            if (a_op !== e_aop) begin
                n_fail++;
                $display("FAIL exec_a_op: instr=%h a_op=%0d expected %0d", w, a_op, e_aop);
            end
        end
        if (e_str[2]) begin
            n_checks++;
            if (b_op !== e_bop) begin
                n_fail++;
                $display("FAIL exec_b_op: instr=%h b_op=%0d expected %0d", w, b_op, e_bop);
            end
        end
        if (e_str[1] || e_str[0]) begin
            n_checks++;
            if (alu_op !== e_alu) begin
                n_fail++;
                $display("FAIL exec_alu_op: instr=%h alu=%h expected %h", w, alu_op, e_alu);
            end
        end
        run = 1'($urandom_range(0, 1));
        @(negedge clk);
        m_pc = e_pc;
        m_halted = e_halt;
        m_ill = e_ill;
        n_checks++;
        if (pc_out !== m_pc || halted !== m_halted || strobes !== 4'b0000) begin
            n_fail++;
            $display("FAIL post_exec: instr=%h pc=%h halted=%b strobes=%b expected pc=%h halted=%b strobes=0000",
                     w, pc_out, halted, strobes, m_pc, m_halted);
        end
`ifdef SEQ_TRAP_ILLEGAL_EN
        n_checks++;
        if (illegal_out !== m_ill) begin
            n_fail++;
            $display("FAIL illegal_flag: got %b expected %b", illegal_out, m_ill);
        end
`endif
    endtask

    task automatic test_reset();
        clear_mem();
        apply_reset();
    endtask

    task automatic test_lda_imm();
        clear_mem();
        mem[0] = 16'h102A;
        apply_reset();
        do_instr(0, 0);
        n_checks++;
        if (pc_out !== 8'h01) begin
            n_fail++;
            $display("FAIL lda_next_pc: pc=%h expected 01", pc_out);
        end
    endtask

    task automatic test_cmp_jmpc();
        clear_mem();
        mem[0] = 16'h4105;
        mem[1] = 16'h6040;
        apply_reset();
        do_instr(1, 0);
        do_instr(1, 0);
        n_checks++;
        if (pc_out !== 8'h40) begin
            n_fail++;
            $display("FAIL jmpc_taken: pc=%h expected 40", pc_out);
        end
        apply_reset();
        do_instr(0, 0);
        do_instr(0, 0);
        n_checks++;
        if (pc_out !== 8'h02) begin
            n_fail++;
            $display("FAIL jmpc_not_taken: pc=%h expected 02", pc_out);
        end
    endtask

    task automatic test_lda_ram();
        clear_mem();
        mem[1] = 16'h1110;
        apply_reset();
        do_instr(2, 0);
        do_instr(2, 1);
    endtask

    task automatic test_pc_wrap();
        clear_mem();
        mem[0] = 16'h50FF;
        apply_reset();
        do_instr(2, 0);
        do_instr(2, 0);
        n_checks++;
        if (pc_out !== 8'h00) begin
            n_fail++;
            $display("FAIL pc_wrap: pc=%h expected 00", pc_out);
        end
    endtask

    task automatic test_halt();
        clear_mem();
        mem[2] = 16'h7000;
        apply_reset();
        for (int i = 0; i < 3; i++) do_instr(2, 1);
        for (int i = 0; i < 20; i++) begin
            run = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_checks++;
            if (pc_out !== 8'h02 || halted !== 1'b1 || strobes !== 4'b0000) begin
                n_fail++;
                $display("FAIL halt_frozen: pc=%h halted=%b strobes=%b expected pc=02 halted=1 strobes=0000",
                         pc_out, halted, strobes);
            end
        end
    endtask

    task automatic test_reset_mid_exec();
        clear_mem();
        mem[0] = 16'h102A;
        apply_reset();
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (strobes !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_in_exec_strobes: strobes=%b expected 0000", strobes);
        end
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (pc_out !== 8'h00 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_exec_pc: pc=%h halted=%b expected pc=00 halted=0", pc_out, halted);
        end
        m_pc = 8'h00;
        m_halted = 0;
        m_ill = 0;
        do_instr(2, 0);
    endtask

    task automatic test_illegal();
        clear_mem();
        mem[0] = 16'h9000;
        apply_reset();
        do_instr(2, 0);
        do_instr(2, 0);
    endtask

    task automatic test_random();
        logic [3:0] r;
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < 256; i++) begin
                r = 4'($urandom_range(0, 15));
                if (r == 4'h7 && $urandom_range(0, 3) != 0) r = 4'h0;
                mem[i] = {r, 12'($urandom)};
            end
            apply_reset();
            for (int k = 0; k < 40; k++) do_instr(2, 1);
        end
    endtask

    initial begin
        test_reset();
        test_lda_imm();
        test_cmp_jmpc();
        test_lda_ram();
        test_pc_wrap();
        test_halt();
        test_reset_mid_exec();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/word_unit_sequencer.md
Name: word_unit_sequencer

Overview:
- Per-core instruction fetch/decode/issue sequencer sitting directly upstream of the word unit.
- Fetches 16-bit instructions from synchronous program memory and decodes them into the word unit's control strobes: A/B write enables and opcodes, ALU opcode, OV enable, comparator-register enable and immediate argument.
- Consumes the word unit's comparator result for conditional jumps.
- Fixed 3-cycle non-pipelined instruction cycle.

Parameters:
- PC_W, 8, program counter width in bits; program space is 2^PC_W words.

Ports:
- CLK  in  1  core clock; all state updates on its rising edge.
- CPU_Reset  in  1  reset, synchronous, active-high.
- SEQ_Run  in  1  1 = allow new fetches; 0 = stall at FETCH.
- SEQ_PC  out  PC_W  program memory address.
- SEQ_Instr  in  16  program memory read data, valid one cycle after SEQ_PC is sampled.
- SEQ_RAMAddr  out  8  data RAM read address (synchronous RAM, 1-cycle latency).
- SEQ_ComparatorResoult  in  1  registered comparator result from the word unit.
- SEQ_A_WE / SEQ_B_WE  out  1  accumulator A/B write strobes.
- SEQ_A_OPCode / SEQ_B_OPCode  out  2  source select: 0 = arg, 1 = RAM, 2 = register, 3 = any-data input.
- SEQ_ALU_OPCode  out  4  ALU operation.
- SEQ_OV_EN  out  1  overflow flag update enable.
- SEQ_COMPARATORREG_EN  out  1  comparator register update enable.
- SEQ_ArgToSet  out  8  immediate argument (IR[7:0]).
- SEQ_Halted  out  1  core has executed HALT.

Behaviour:
- Instruction format: [15:12] class, [11:8] sub, [7:0] arg.
- FSM states: FETCH, DECODE, EXEC, HALT.
- FETCH: SEQ_PC = PC.
  - SEQ_Run=1 → DECODE.
  - SEQ_Run=0 → stay in FETCH; PC is unchanged.
- DECODE: IR <= SEQ_Instr; SEQ_RAMAddr = SEQ_Instr[7:0] (combinational) so RAM data is valid during EXEC → EXEC.
- EXEC: strobes are decoded from IR, asserted for exactly this one cycle.
  - PC is updated at the end of EXEC.
  - Next state is FETCH, or HALT for the HALT class.
  - SEQ_Run is ignored once DECODE has been entered; an in-flight instruction always completes.
- Outside EXEC: all strobes (WE, OV_EN, COMPARATORREG_EN) are 0. Opcode and arg outputs reflect IR and are don't-care to the consumer.
- SEQ_RAMAddr = IR[7:0] outside DECODE.
- Class decode (in EXEC):
  - 0x0 NOP: no strobes.
  - 0x1 LDA: A_WE=1, A_OPCode=sub[1:0].
  - 0x2 LDB: B_WE=1, B_OPCode=sub[1:0].
  - 0x3 ALU: ALU_OPCode=sub, A_WE=1, A_OPCode=3, OV_EN=1.
  - 0x4 CMP: ALU_OPCode=sub, COMPARATORREG_EN=1.
  - 0x5 JMP: PC <= arg[PC_W-1:0].
  - 0x6 JMPC: PC <= arg if SEQ_ComparatorResoult=1, else PC+1.
  - 0x7 HALT: → HALT, SEQ_Halted=1; PC is not incremented.
  - 0x8–0xF: illegal (see Optional Feature).
- PC arithmetic: PC+1 modulo 2^PC_W; 2^PC_W-1 wraps to 0. If PC_W<8, the jump target is truncated to its low PC_W bits.
- HALT state: no fetches, no strobes. Exit only via CPU_Reset.
- Comparator timing: CMP's result registers at the end of its EXEC; the next JMPC EXEC comes ≥3 cycles later, so no hazard.
- Reset (any state, including mid-EXEC): state=FETCH, PC=0, IR=0, SEQ_Halted=0, all strobes 0 in the same cycle the reset is sampled.

Optional Feature:
- SEQ_TRAP_ILLEGAL_EN
  - Defined: illegal class → HALT, SEQ_Halted=1, plus an extra output SEQ_Illegal=1 that is sticky until reset.
  - Undefined: illegal class executes as NOP (PC+1); no SEQ_Illegal port.

Test Plan:
- Reset, SEQ_Run=1, mem[0]=0x102A (LDA arg 0x2A) → A_WE=1, A_OPCode=0, ArgToSet=0x2A in cycle 3 only; SEQ_PC=1 in cycle 4.
- mem[0]=0x4105 (CMP), SEQ_ComparatorResoult driven 1, mem[1]=0x6040 → COMPARATORREG_EN pulse in cycle 3; PC=0x40 after the JMPC EXEC. Repeat with result 0 → PC=2.
- mem[1]=0x1110 (LDA RAM 0x10) → SEQ_RAMAddr=0x10 during DECODE of the word at PC=1; A_WE=1, A_OPCode=1 in the following EXEC.
- PC preloaded to 0xFF via mem[0]=0x50FF, mem[0xFF]=NOP → SEQ_PC wraps to 0x00.
- mem[2]=0x7000 → SEQ_Halted=1; SEQ_PC frozen at 2 for 20 cycles; no strobes. SEQ_Run=0 at FETCH → PC held; Run raised → resumes.
- CPU_Reset asserted during an EXEC of LDA → A_WE=0 in that cycle; next cycle state=FETCH, PC=0. Illegal 0x9000 → NOP (PC+1), or HALT with SEQ_Illegal=1 when SEQ_TRAP_ILLEGAL_EN is defined.
